// File: rtl/vga_pixel_ce_gen.sv
// Phase-accumulator pixel clock-enable for VIDEO_ID_CODE 1-4 (optional ce_count window monitor: VGA_PIXEL_CE_MONITOR_EN).
// pix_ce is registered one cycle after the carry; mode_ready is low while draining/settling, so requesters hold mode_valid.
module vga_pixel_ce_gen #(
  parameter int CLK_HZ                = 148_500_000,
  parameter int ACC_WIDTH             = 32,
  parameter int DEFAULT_VIDEO_ID_CODE = 1,
  parameter int SETTLE_CYCLES         = 64,
  parameter int MON_LOG2              = 10
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [1:0]  mode_sel,
  input  logic        mode_valid,
  output logic        mode_ready,
  output logic        pix_ce,
  output logic        pix_clk,
  output logic        locked,
  output logic [1:0]  cur_mode
`ifdef VGA_PIXEL_CE_MONITOR_EN
  ,
  output logic [15:0] ce_count
`endif
);

  localparam logic [63:0] CLK64   = 64'(CLK_HZ);
  localparam logic [63:0] F_CODE1 = 64'd25_200_000;
  localparam logic [63:0] F_CODE2 = 64'd27_000_000;
  localparam logic [63:0] F_CODE4 = 64'd74_250_000;

  // Long division keeps one extra quotient bit so the increment is rounded, not truncated.
  function automatic logic [ACC_WIDTH-1:0] calc_inc(input logic [63:0] f_pix);
    logic [63:0]        rem;
    logic [ACC_WIDTH:0] q;
    rem = f_pix;
    q   = '0;
    for (int i = 0; i <= ACC_WIDTH; i++) begin
      rem = rem << 1;
      if (rem >= CLK64) begin
        rem = rem - CLK64;
        q   = {q[ACC_WIDTH-1:0], 1'b1};
      end else begin
        q   = {q[ACC_WIDTH-1:0], 1'b0};
      end
    end
    return q[ACC_WIDTH:1] + ACC_WIDTH'(q[0]);
  endfunction

  localparam logic [ACC_WIDTH-1:0] INC_C1 = calc_inc(F_CODE1);
  localparam logic [ACC_WIDTH-1:0] INC_C2 = calc_inc(F_CODE2);
  localparam logic [ACC_WIDTH-1:0] INC_C4 = calc_inc(F_CODE4);

  function automatic logic [ACC_WIDTH-1:0] inc_of(input logic [1:0] m);
    case (m)
      2'd0:       return INC_C1;
      2'd1, 2'd2: return INC_C2;
      default:    return INC_C4;
    endcase
  endfunction

  if (ACC_WIDTH < 16 || ACC_WIDTH > 48) begin : g_bad_acc_width
    $error("vga_pixel_ce_gen: ACC_WIDTH must be 16..48");
  end
  if (DEFAULT_VIDEO_ID_CODE < 1 || DEFAULT_VIDEO_ID_CODE > 4) begin : g_bad_default
    $error("vga_pixel_ce_gen: DEFAULT_VIDEO_ID_CODE must be 1..4");
  end
  if (SETTLE_CYCLES < 1 || MON_LOG2 < 1) begin : g_bad_counts
    $error("vga_pixel_ce_gen: SETTLE_CYCLES and MON_LOG2 must be at least 1");
  end
  if (F_CODE4 * 64'd2 > CLK64) begin : g_bad_clk
    $error("vga_pixel_ce_gen: CLK_HZ too low for 74.25 MHz pixel rate");
  end

  localparam int              CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [1:0]      DEF_MODE = 2'(DEFAULT_VIDEO_ID_CODE - 1);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [ACC_WIDTH-1:0]   inc_q, inc_d;
  logic [1:0]             mode_q, mode_d;
  logic [1:0]             pend_q, pend_d;
  logic                   pix_ce_q, pix_ce_d;
  logic                   pix_clk_q;
  logic                   carry;
  logic [ACC_WIDTH-1:0]   acc_sum;

  assign {carry, acc_sum} = {1'b0, acc_q} + {1'b0, inc_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    inc_d    = inc_q;
    mode_d   = mode_q;
    pend_d   = pend_q;
    pix_ce_d = 1'b0;
    case (state_q)
      ST_SETTLE: begin
        acc_d = '0;
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_RUN: begin
        acc_d    = acc_sum;
        pix_ce_d = carry;
        if (mode_valid) begin
          pend_d = mode_sel;
          if (mode_sel != mode_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        acc_d    = acc_sum;
        pix_ce_d = carry;
        // Switch only on a pixel boundary so the last old-rate pixel is never truncated.
        if (carry) begin
          inc_d   = inc_of(pend_q);
          mode_d  = pend_q;
          acc_d   = '0;
          cnt_d   = CNT_INIT;
          state_d = ST_SETTLE;
        end
      end
      default: begin
        acc_d   = '0;
        cnt_d   = CNT_INIT;
        state_d = ST_SETTLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= ST_SETTLE;
      cnt_q     <= CNT_INIT;
      acc_q     <= '0;
      inc_q     <= inc_of(DEF_MODE);
      mode_q    <= DEF_MODE;
      pend_q    <= DEF_MODE;
      pix_ce_q  <= 1'b0;
      pix_clk_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      inc_q     <= inc_d;
      mode_q    <= mode_d;
      pend_q    <= pend_d;
      pix_ce_q  <= pix_ce_d;
      pix_clk_q <= acc_q[ACC_WIDTH-1];
    end
  end

  assign mode_ready = (state_q == ST_RUN);
  assign locked     = (state_q != ST_SETTLE);
  assign pix_ce     = pix_ce_q;
  assign pix_clk    = pix_clk_q;
  assign cur_mode   = mode_q;

`ifdef VGA_PIXEL_CE_MONITOR_EN
  logic [MON_LOG2-1:0] win_q;
  logic [15:0]         pcnt_q, pcnt_d;
  logic [15:0]         ce_count_q;
  logic [16:0]         pcnt_sum;

  // The wrap cycle's own pulse belongs to the closing window.
  assign pcnt_sum = {1'b0, pcnt_q} + 17'(pix_ce_q);
  assign pcnt_d   = pcnt_sum[16] ? 16'hFFFF : pcnt_sum[15:0];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      win_q      <= '0;
      pcnt_q     <= '0;
      ce_count_q <= '0;
    end else begin
      win_q <= win_q + MON_LOG2'(1);
      if (&win_q) begin
        ce_count_q <= pcnt_d;
        pcnt_q     <= '0;
      end else begin
        pcnt_q     <= pcnt_d;
      end
    end
  end

  assign ce_count = ce_count_q;
`endif

endmodule
